// File: rtl/lsq_unified_fwd_if.sv
// Bundle of dispatch, AGU, commit, data-cache and CDB signals around the unified load/store queue.
// master = surrounding pipeline / memory side, slave = the queue itself.
`timescale 1ns/1ps
interface lsq_unified_fwd_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             flush;
  logic             alloc_valid;
  logic             alloc_ready;
  logic             alloc_store;
  logic [3:0]       alloc_mask;
  logic             alloc_signed;
  logic [TAG_W-1:0] alloc_tag;
  logic [IDX_W-1:0] alloc_idx;
  logic             agu_valid;
  logic [IDX_W-1:0] agu_idx;
  logic [XLEN-1:0]  agu_addr;
  logic [XLEN-1:0]  agu_wdata;
  logic             commit_store;
  logic [XLEN-1:0]  dmem_addr;
  logic [3:0]       dmem_rmask;
  logic [3:0]       dmem_wmask;
  logic [XLEN-1:0]  dmem_wdata;
  logic [XLEN-1:0]  dmem_rdata;
  logic             dmem_resp;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             cdb_is_store;

  modport master (
    output flush, alloc_valid, alloc_store, alloc_mask, alloc_signed, alloc_tag,
           agu_valid, agu_idx, agu_addr, agu_wdata, commit_store, dmem_rdata, dmem_resp,
    input  alloc_ready, alloc_idx, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           cdb_valid, cdb_tag, cdb_data, cdb_is_store
  );

  modport slave (
    input  flush, alloc_valid, alloc_store, alloc_mask, alloc_signed, alloc_tag,
           agu_valid, agu_idx, agu_addr, agu_wdata, commit_store, dmem_rdata, dmem_resp,
    output alloc_ready, alloc_idx, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           cdb_valid, cdb_tag, cdb_data, cdb_is_store
  );
endinterface

// File: rtl/lsq_unified_fwd.sv
// Unified age-ordered load/store queue with a single outstanding dmem request.
// Define LSQ_STORE_FWD_EN to build store-to-load forwarding; otherwise overlapping older stores block loads.
`timescale 1ns/1ps
module lsq_unified_fwd #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input logic              clk,
  input logic              rst,
  lsq_unified_fwd_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, REQ_LD, REQ_ST, RESP} state_t;

  state_t           state_q, state_d;
  logic             kill_q, kill_d;
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d, st_q, st_d, sgn_q, sgn_d, aok_q, aok_d, done_q, done_d;
  logic [3:0]       mask_q [DEPTH];
  logic [3:0]       mask_d [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] tag_d  [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  addr_d [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];

  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic [XLEN-1:0]  req_addr_q, req_addr_d, req_wdata_q, req_wdata_d, res_data_q, res_data_d;
  logic [3:0]       req_smask_q, req_smask_d, req_mask_q, req_mask_d;
  logic             req_sgn_q, req_sgn_d, req_st_q, req_st_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;

  logic             idle_ok, alloc_rdy, st_go, mem_go, fw_go, fw_fire, do_ret, do_acc;
  logic [IDX_W-1:0] mem_idx, fw_idx, iss_idx;
  logic [XLEN-1:0]  fw_data;

  function automatic logic [3:0] shmask(input logic [3:0] m, input logic [1:0] off);
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] st_align(input logic [XLEN-1:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  // Realign a memory word to the load's byte offset, then size and extend it.
  function automatic logic [XLEN-1:0] ld_ext(input logic [XLEN-1:0] w, input logic [1:0] off,
                                             input logic [3:0] m, input logic s);
    logic [XLEN-1:0] r;
    r = w >> {off, 3'b000};
    case (m)
      4'b0001: ld_ext = {{(XLEN-8){s & r[7]}}, r[7:0]};
      4'b0011: ld_ext = {{(XLEN-16){s & r[15]}}, r[15:0]};
      default: ld_ext = r;
    endcase
  endfunction

  assign alloc_rdy       = (count_q != CW'(DEPTH));
  assign bus.alloc_ready = alloc_rdy;
  assign bus.alloc_idx   = tail_q;
  assign idle_ok         = (state_q == IDLE) && !bus.flush;
  assign st_go           = idle_ok && vld_q[head_q] && st_q[head_q] && aok_q[head_q] &&
                           !done_q[head_q] && bus.commit_store;

  // Load selection: walk loads youngest to oldest so the oldest candidate is written last.
  always_comb begin
    logic [IDX_W-1:0] li, sc;
    logic [3:0]       lm;
    logic             blk, hit;
`ifdef LSQ_STORE_FWD_EN
    logic [IDX_W-1:0] sj;
    sj = '0;
`endif
    mem_go = 1'b0; mem_idx = '0; fw_go = 1'b0; fw_idx = '0; fw_data = '0;
    li = '0; sc = '0; lm = '0; blk = 1'b0; hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      li  = head_q + IDX_W'(k);
      lm  = shmask(mask_q[li], addr_q[li][1:0]);
      blk = 1'b0;
      hit = 1'b0;
      for (int m = 0; m < DEPTH; m++) begin
        sc = head_q + IDX_W'(m);
        if (m < k && vld_q[sc] && st_q[sc]) begin
          if (!aok_q[sc]) blk = 1'b1;
          else if (addr_q[sc][XLEN-1:2] == addr_q[li][XLEN-1:2] &&
                   (shmask(mask_q[sc], addr_q[sc][1:0]) & lm) != 4'b0000) begin
            hit = 1'b1;
`ifdef LSQ_STORE_FWD_EN
            sj = sc;
`endif
          end
        end
      end
      if (vld_q[li] && !st_q[li] && aok_q[li] && !done_q[li] && !blk) begin
        if (!hit) begin
          mem_go  = idle_ok;
          mem_idx = li;
        end
`ifdef LSQ_STORE_FWD_EN
        else if ((lm & ~shmask(mask_q[sj], addr_q[sj][1:0])) == 4'b0000) begin
          fw_go   = idle_ok;
          fw_idx  = li;
          fw_data = ld_ext(st_align(data_q[sj], addr_q[sj][1:0]), addr_q[li][1:0],
                           mask_q[li], sgn_q[li]);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
    st_q        <= st_d;
    sgn_q       <= sgn_d;
    aok_q       <= aok_d;
    done_q      <= done_d;
    mask_q      <= mask_d;
    tag_q       <= tag_d;
    addr_q      <= addr_d;
    data_q      <= data_d;
    req_idx_q   <= req_idx_d;
    req_addr_q  <= req_addr_d;
    req_wdata_q <= req_wdata_d;
    req_smask_q <= req_smask_d;
    req_mask_q  <= req_mask_d;
    req_sgn_q   <= req_sgn_d;
    req_st_q    <= req_st_d;
    req_tag_q   <= req_tag_d;
    res_data_q  <= res_data_d;
  end

  // A flushed request still waits for its response, then drops back to IDLE silently.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        if (st_go) state_d = REQ_ST;
        else if (mem_go) state_d = REQ_LD;
      end
      REQ_LD, REQ_ST: begin
        if (bus.flush) kill_d = 1'b1;
        if (bus.dmem_resp) begin
          state_d = (kill_q || bus.flush) ? IDLE : RESP;
          kill_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.dmem_addr    = {req_addr_q[XLEN-1:2], 2'b00};
    bus.dmem_rmask   = (state_q == REQ_LD) ? req_smask_q : 4'b0000;
    bus.dmem_wmask   = (state_q == REQ_ST) ? req_smask_q : 4'b0000;
    bus.dmem_wdata   = req_wdata_q;
    fw_fire          = fw_go && !st_go && !mem_go;
    bus.cdb_valid    = 1'b0;
    bus.cdb_tag      = '0;
    bus.cdb_data     = '0;
    bus.cdb_is_store = 1'b0;
    if (state_q == RESP) begin
      bus.cdb_valid    = 1'b1;
      bus.cdb_tag      = req_tag_q;
      bus.cdb_data     = res_data_q;
      bus.cdb_is_store = req_st_q;
    end else if (fw_fire) begin
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = tag_q[fw_idx];
      bus.cdb_data  = fw_data;
    end
  end

  always_comb begin
    head_d = head_q; tail_d = tail_q; count_d = count_q;
    vld_d = vld_q; st_d = st_q; sgn_d = sgn_q; aok_d = aok_q; done_d = done_q;
    mask_d = mask_q; tag_d = tag_q; addr_d = addr_q; data_d = data_q;
    req_idx_d = req_idx_q; req_addr_d = req_addr_q; req_wdata_d = req_wdata_q;
    req_smask_d = req_smask_q; req_mask_d = req_mask_q; req_sgn_d = req_sgn_q;
    req_st_d = req_st_q; req_tag_d = req_tag_q; res_data_d = res_data_q;
    iss_idx = st_go ? head_q : mem_idx;
    if (st_go || mem_go) begin
      req_idx_d   = iss_idx;
      req_addr_d  = addr_q[iss_idx];
      req_wdata_d = st_align(data_q[iss_idx], addr_q[iss_idx][1:0]);
      req_smask_d = shmask(mask_q[iss_idx], addr_q[iss_idx][1:0]);
      req_mask_d  = mask_q[iss_idx];
      req_sgn_d   = sgn_q[iss_idx];
      req_tag_d   = tag_q[iss_idx];
      req_st_d    = st_go;
    end
    if ((state_q == REQ_LD || state_q == REQ_ST) && bus.dmem_resp)
      res_data_d = req_st_q ? '0 : ld_ext(bus.dmem_rdata, req_addr_q[1:0], req_mask_q, req_sgn_q);
    if (state_q == RESP) done_d[req_idx_q] = 1'b1;
    if (fw_fire) done_d[fw_idx] = 1'b1;
    if (bus.agu_valid && vld_q[bus.agu_idx]) begin
      aok_d[bus.agu_idx]  = 1'b1;
      addr_d[bus.agu_idx] = bus.agu_addr;
      data_d[bus.agu_idx] = bus.agu_wdata;
    end
    do_ret = vld_q[head_q] && done_q[head_q];
    do_acc = bus.alloc_valid && alloc_rdy;
    if (do_ret) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + IDX_W'(1);
    end
    if (do_acc) begin
      vld_d[tail_q]  = 1'b1;
      st_d[tail_q]   = bus.alloc_store;
      sgn_d[tail_q]  = bus.alloc_signed;
      mask_d[tail_q] = bus.alloc_mask;
      tag_d[tail_q]  = bus.alloc_tag;
      aok_d[tail_q]  = 1'b0;
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + IDX_W'(1);
    end
    count_d = count_q + CW'(do_acc) - CW'(do_ret);
    if (bus.flush) begin
      vld_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end
endmodule

// File: tb/tb_lsq_unified_fwd.sv
// Directed bench for lsq_unified_fwd: full/wrap, forwarding or blocking, partial overlap,
// byte-load extension, flush during an outstanding load, and stall on an unknown store address.
`timescale 1ns/1ps
module tb_lsq_unified_fwd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  lsq_unified_fwd_if #(.DEPTH(8), .TAG_W(6), .XLEN(32)) bus ();

  lsq_unified_fwd #(.DEPTH(8), .TAG_W(6), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic st, input logic [3:0] m, input logic s,
                          input logic [5:0] t, input logic [2:0] exp_idx);
    bus.alloc_valid  = 1'b1;
    bus.alloc_store  = st;
    bus.alloc_mask   = m;
    bus.alloc_signed = s;
    bus.alloc_tag    = t;
    #1;
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(1));
    chk("alloc_idx", 32'(bus.alloc_idx), 32'(exp_idx));
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_agu(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    bus.agu_valid = 1'b1;
    bus.agu_idx   = idx;
    bus.agu_addr  = a;
    bus.agu_wdata = d;
    tick();
    bus.agu_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [5:0] t,
                         input logic [31:0] d, input logic s);
    chk({tag, "_valid"}, 32'(bus.cdb_valid), 32'(v));
    chk({tag, "_tag"}, 32'(bus.cdb_tag), 32'(t));
    chk({tag, "_data"}, bus.cdb_data, d);
    chk({tag, "_is_store"}, 32'(bus.cdb_is_store), 32'(s));
  endtask

  initial begin
    bus.flush = 0; bus.alloc_valid = 0; bus.alloc_store = 0; bus.alloc_mask = 0;
    bus.alloc_signed = 0; bus.alloc_tag = 0; bus.agu_valid = 0; bus.agu_idx = 0;
    bus.agu_addr = 0; bus.agu_wdata = 0; bus.commit_store = 0; bus.dmem_rdata = 0;
    bus.dmem_resp = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'(1));
    chk("rst_alloc_idx", 32'(bus.alloc_idx), 32'(0));
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'(0));
    chk("rst_rmask", 32'(bus.dmem_rmask), 32'(0));
    chk("rst_wmask", 32'(bus.dmem_wmask), 32'(0));

    // Fill with eight loads, attempt a ninth, retire the head.
    for (int i = 0; i < 8; i++) do_alloc(1'b0, 4'b1111, 1'b0, 6'(i), 3'(i));
    chk("full_ready", 32'(bus.alloc_ready), 32'(0));
    chk("full_idx", 32'(bus.alloc_idx), 32'(0));
    bus.alloc_valid = 1'b1; bus.alloc_tag = 6'd9;
    tick();
    bus.alloc_valid = 1'b0;
    chk("full_ignored_idx", 32'(bus.alloc_idx), 32'(0));
    chk("full_ignored_ready", 32'(bus.alloc_ready), 32'(0));
    do_agu(3'd0, 32'h200, 32'h0);
    chk("t1_idle_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    chk("t1_rmask", 32'(bus.dmem_rmask), 32'hF);
    chk("t1_addr", bus.dmem_addr, 32'h200);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t1_cdb", 1'b1, 6'd0, 32'h1234_5678, 1'b0);
    tick();
    chk("t1_done_ready", 32'(bus.alloc_ready), 32'(0));
    chk("t1_done_cdb", 32'(bus.cdb_valid), 32'(0));
    tick();
    chk("t1_retire_ready", 32'(bus.alloc_ready), 32'(1));
    chk("t1_retire_idx", 32'(bus.alloc_idx), 32'(0));
    do_flush();
    chk("t1_flush_idx", 32'(bus.alloc_idx), 32'(0));

    // SW 0xDEADBEEF @0x100 then LW @0x100.
    do_alloc(1'b1, 4'b1111, 1'b0, 6'd10, 3'd0);
    do_alloc(1'b0, 4'b1111, 1'b0, 6'd11, 3'd1);
    do_agu(3'd0, 32'h100, 32'hDEAD_BEEF);
    do_agu(3'd1, 32'h100, 32'h0);
`ifdef LSQ_STORE_FWD_EN
    chk_cdb("t2_fwd", 1'b1, 6'd11, 32'hDEAD_BEEF, 1'b0);
    chk("t2_fwd_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    bus.commit_store = 1'b1;
    #1;
    chk("t2_after_fwd_cdb", 32'(bus.cdb_valid), 32'(0));
    tick();
    bus.commit_store = 1'b0;
    chk("t2_wmask", 32'(bus.dmem_wmask), 32'hF);
    chk("t2_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
    chk("t2_st_rmask", 32'(bus.dmem_rmask), 32'(0));
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t2_st_cdb", 1'b1, 6'd10, 32'h0, 1'b1);
    tick();
    tick();
`else
    chk("t2_block_cdb", 32'(bus.cdb_valid), 32'(0));
    chk("t2_block_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    chk("t2_block_cdb2", 32'(bus.cdb_valid), 32'(0));
    bus.commit_store = 1'b1;
    tick();
    bus.commit_store = 1'b0;
    chk("t2_wmask", 32'(bus.dmem_wmask), 32'hF);
    chk("t2_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t2_st_cdb", 1'b1, 6'd10, 32'h0, 1'b1);
    tick();
    chk("t2_retire_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    chk("t2_issue_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    chk("t2_ld_rmask", 32'(bus.dmem_rmask), 32'hF);
    chk("t2_ld_addr", bus.dmem_addr, 32'h100);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t2_ld_cdb", 1'b1, 6'd11, 32'hDEAD_BEEF, 1'b0);
    tick();
`endif
    do_flush();

    // SB 0x7F @0x103 then LW @0x100: partial overlap.
    do_alloc(1'b1, 4'b0001, 1'b0, 6'd20, 3'd0);
    do_alloc(1'b0, 4'b1111, 1'b0, 6'd21, 3'd1);
    do_agu(3'd0, 32'h103, 32'h7F);
    do_agu(3'd1, 32'h100, 32'h0);
    chk("t3_wait_cdb", 32'(bus.cdb_valid), 32'(0));
    chk("t3_wait_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    chk("t3_wait_cdb2", 32'(bus.cdb_valid), 32'(0));
    bus.commit_store = 1'b1;
    tick();
    bus.commit_store = 1'b0;
    chk("t3_wmask", 32'(bus.dmem_wmask), 32'b1000);
    chk("t3_wdata", bus.dmem_wdata, 32'h7F00_0000);
    chk("t3_st_addr", bus.dmem_addr, 32'h100);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t3_st_cdb", 1'b1, 6'd20, 32'h0, 1'b1);
    tick();
    chk("t3_retire_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    tick();
    chk("t3_ld_rmask", 32'(bus.dmem_rmask), 32'hF);
    chk("t3_ld_addr", bus.dmem_addr, 32'h100);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h7F00_0000;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t3_ld_cdb", 1'b1, 6'd21, 32'h7F00_0000, 1'b0);
    tick();
    do_flush();

    // LB / LBU @0x102 with rdata 0x00800000.
    do_alloc(1'b0, 4'b0001, 1'b1, 6'd30, 3'd0);
    do_agu(3'd0, 32'h102, 32'h0);
    tick();
    chk("t4_lb_addr", bus.dmem_addr, 32'h100);
    chk("t4_lb_rmask", 32'(bus.dmem_rmask), 32'b0100);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0080_0000;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t4_lb_cdb", 1'b1, 6'd30, 32'hFFFF_FF80, 1'b0);
    tick();
    do_flush();
    do_alloc(1'b0, 4'b0001, 1'b0, 6'd31, 3'd0);
    do_agu(3'd0, 32'h102, 32'h0);
    tick();
    chk("t4_lbu_rmask", 32'(bus.dmem_rmask), 32'b0100);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t4_lbu_cdb", 1'b1, 6'd31, 32'h0000_0080, 1'b0);
    tick();
    do_flush();

    // Flush while a load is outstanding; response arrives three cycles later.
    do_alloc(1'b0, 4'b1111, 1'b0, 6'd40, 3'd0);
    do_agu(3'd0, 32'h300, 32'h0);
    tick();
    chk("t5_rmask", 32'(bus.dmem_rmask), 32'hF);
    chk("t5_addr", bus.dmem_addr, 32'h300);
    do_flush();
    for (int i = 0; i < 2; i++) begin
      chk("t5_hold_rmask", 32'(bus.dmem_rmask), 32'hF);
      chk("t5_hold_addr", bus.dmem_addr, 32'h300);
      chk("t5_hold_cdb", 32'(bus.cdb_valid), 32'(0));
      chk("t5_hold_idx", 32'(bus.alloc_idx), 32'(0));
      tick();
    end
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h5555_5555;
    #1;
    chk("t5_resp_rmask", 32'(bus.dmem_rmask), 32'hF);
    tick();
    bus.dmem_resp = 1'b0;
    chk("t5_after_cdb", 32'(bus.cdb_valid), 32'(0));
    chk("t5_after_rmask", 32'(bus.dmem_rmask), 32'(0));
    chk("t5_after_ready", 32'(bus.alloc_ready), 32'(1));
    chk("t5_after_idx", 32'(bus.alloc_idx), 32'(0));
    tick();
    chk("t5_after_cdb2", 32'(bus.cdb_valid), 32'(0));

    // Older store with unknown address stalls a ready younger load.
    do_alloc(1'b1, 4'b1111, 1'b0, 6'd50, 3'd0);
    do_alloc(1'b0, 4'b1111, 1'b0, 6'd51, 3'd1);
    do_agu(3'd1, 32'h400, 32'h0);
    chk("t6_stall_rmask", 32'(bus.dmem_rmask), 32'(0));
    chk("t6_stall_cdb", 32'(bus.cdb_valid), 32'(0));
    tick();
    chk("t6_stall_rmask2", 32'(bus.dmem_rmask), 32'(0));
    do_agu(3'd0, 32'h500, 32'h1);
    chk("t6_decide_rmask", 32'(bus.dmem_rmask), 32'(0));
    tick();
    chk("t6_ld_rmask", 32'(bus.dmem_rmask), 32'hF);
    chk("t6_ld_addr", bus.dmem_addr, 32'h400);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0000_0055;
    tick();
    bus.dmem_resp = 1'b0;
    chk_cdb("t6_cdb", 1'b1, 6'd51, 32'h0000_0055, 1'b0);
    tick();
    do_flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
